// File: rtl/reg_pkg.sv
// Shared widths, bitmap control encodings and entry type for the register
// release path.
package reg_pkg;

  localparam int unsigned REG_CNT_DEF  = 64;
  localparam int unsigned ARCH_CNT_DEF = 32;
  localparam int unsigned PW_DEF       = $clog2(REG_CNT_DEF);
  localparam int unsigned AW_DEF       = $clog2(ARCH_CNT_DEF);

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_CLAIM = 2'b01;
  localparam logic [1:0] CTRL_FREE  = 2'b10;

  typedef logic [PW_DEF-1:0] rf_entry;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/release_fifo.sv
// Ordered two-push, one-pop queue of freed physical register indices.
// Port 0 is written ahead of port 1 when both push in the same cycle.
module release_fifo
  import reg_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = PW_DEF,
  localparam int unsigned CW   = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push0_i,
  input  logic [W-1:0]  data0_i,
  input  logic          push1_i,
  input  logic [W-1:0]  data1_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PTRW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push0_i) begin
      mem_d[wr_d] = data0_i;
      wr_d        = wr_d + PTRW'(1);
    end
    if (push1_i) begin
      mem_d[wr_d] = data1_i;
      wr_d        = wr_d + PTRW'(1);
    end
    if (pop_i) begin
      rd_d = rd_q + PTRW'(1);
    end
    count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/reg_release_unit.sv
// Committed arch-to-phys map plus release queue feeding the bitmap FREE port,
// yielding to allocator claims.
module reg_release_unit
  import reg_pkg::*;
#(
  parameter int unsigned REG_CNT  = REG_CNT_DEF,
  parameter int unsigned ARCH_CNT = ARCH_CNT_DEF,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned PW      = $clog2(REG_CNT),
  localparam int unsigned AW      = $clog2(ARCH_CNT),
  localparam int unsigned CW      = cnt_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RET_VALID,
  input  logic [AW-1:0] RET_ARCH,
  input  logic [PW-1:0] RET_PHYS,
  output logic          RET_READY,
  input  logic          SQ_VALID,
  input  logic [PW-1:0] SQ_PHYS,
  output logic          SQ_READY,
  input  logic          CLAIM_REQ,
  output logic [PW-1:0] FREE,
  output logic [1:0]    CONTROL,
  input  logic [AW-1:0] RD_ARCH,
  output logic [PW-1:0] RD_PHYS,
  output logic [CW-1:0] COUNT
);

  logic [PW-1:0] map_q [ARCH_CNT];
  logic [PW-1:0] map_d [ARCH_CNT];
  logic [PW-1:0] free_q, free_d;
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic          ready, ret_push, sq_push, pop;

  // Room for two pushes keeps the dual-push path from ever overflowing.
  assign ready     = count < CW'(DEPTH - 1);
  assign RET_READY = ready;
  assign SQ_READY  = ready;

  assign ret_push = RET_VALID & ready & (RET_ARCH != '0);
  assign sq_push  = SQ_VALID & ready;
  assign pop      = (count != '0) & ~CLAIM_REQ;

  always_comb begin
    map_d = map_q;
    if (ret_push) begin
      map_d[RET_ARCH] = RET_PHYS;
    end
    free_d  = pop ? head : free_q;
    CONTROL = pop ? CTRL_FREE : CTRL_IDLE;
    FREE    = free_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ARCH_CNT; i++) begin
        map_q[i] <= PW'(i);
      end
      free_q <= '0;
    end else begin
      map_q  <= map_d;
      free_q <= free_d;
    end
  end

  assign RD_PHYS = map_q[RD_ARCH];
  assign COUNT   = count;

  release_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_release_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push0_i (ret_push),
    .data0_i (map_q[RET_ARCH]),
    .push1_i (sq_push),
    .data1_i (SQ_PHYS),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_reg_release_unit.sv
// Bench for reg_release_unit: scoreboard of expected frees plus a committed-map
// model, directed sequences and a table of single-cycle vectors.
module tb_reg_release_unit;
  import reg_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RET_VALID = 1'b0;
  logic [4:0] RET_ARCH = '0;
  rf_entry    RET_PHYS = '0;
  logic       RET_READY;
  logic       SQ_VALID = 1'b0;
  rf_entry    SQ_PHYS = '0;
  logic       SQ_READY;
  logic       CLAIM_REQ = 1'b0;
  rf_entry    FREE;
  logic [1:0] CONTROL;
  logic [4:0] RD_ARCH = '0;
  rf_entry    RD_PHYS;
  logic [3:0] COUNT;

  always #5 CLK = ~CLK;

  reg_release_unit #(
    .REG_CNT  (64),
    .ARCH_CNT (32),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RET_VALID (RET_VALID),
    .RET_ARCH  (RET_ARCH),
    .RET_PHYS  (RET_PHYS),
    .RET_READY (RET_READY),
    .SQ_VALID  (SQ_VALID),
    .SQ_PHYS   (SQ_PHYS),
    .SQ_READY  (SQ_READY),
    .CLAIM_REQ (CLAIM_REQ),
    .FREE      (FREE),
    .CONTROL   (CONTROL),
    .RD_ARCH   (RD_ARCH),
    .RD_PHYS   (RD_PHYS),
    .COUNT     (COUNT)
  );

  int      n_cmp = 0;
  int      n_fail = 0;
  bit      chk_en = 1'b0;
  rf_entry sb[$];
  rf_entry emitted[$];
  rf_entry model_map [32];
  rf_entry last_free;

  typedef struct {
    bit          ret_v;
    logic [4:0]  ret_arch;
    rf_entry     ret_phys;
    bit          sq_v;
    rf_entry     sq_phys;
    bit          claim;
    logic [4:0]  rd_arch;
    rf_entry     exp_rd;
    int unsigned exp_count;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    RET_VALID = 1'b0;
    SQ_VALID  = 1'b0;
  endtask

  // Check outputs against the model, advance the model, then cross one edge.
  task automatic step();
    bit m_ready;
    bit m_pop;
    #1;
    m_ready = (int'(DEPTH) - sb.size()) >= 2;
    m_pop   = (sb.size() > 0) && !CLAIM_REQ;
    if (chk_en) begin
      check("ret_ready", {31'd0, RET_READY}, {31'd0, m_ready});
      check("sq_ready", {31'd0, SQ_READY}, {31'd0, m_ready});
      check("count", {28'd0, COUNT}, sb.size());
      check("rd_phys", {26'd0, RD_PHYS}, {26'd0, model_map[RD_ARCH]});
      if (m_pop) begin
        check("control_free", {30'd0, CONTROL}, {30'd0, CTRL_FREE});
        check("free_head", {26'd0, FREE}, {26'd0, sb[0]});
      end else begin
        check("control_idle", {30'd0, CONTROL}, {30'd0, CTRL_IDLE});
        check("free_hold", {26'd0, FREE}, {26'd0, last_free});
      end
    end
    if (RST) begin
      sb.delete();
      for (int i = 0; i < 32; i++) model_map[i] = rf_entry'(i);
      last_free = '0;
    end else begin
      if (m_pop) begin
        last_free = sb.pop_front();
        emitted.push_back(last_free);
      end
      if (RET_VALID && m_ready && RET_ARCH != 5'd0) begin
        sb.push_back(model_map[RET_ARCH]);
        model_map[RET_ARCH] = RET_PHYS;
      end
      if (SQ_VALID && m_ready) sb.push_back(SQ_PHYS);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    idle();
    CLAIM_REQ = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      step();
      guard++;
    end
    #1;
    check(name, {28'd0, COUNT}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd4, 6'd20, 1'b0, 6'd0,  1'b1, 5'd4, 6'd20, 1};
    vecs[1] = '{1'b1, 5'd4, 6'd21, 1'b1, 6'd33, 1'b1, 5'd4, 6'd21, 3};
    vecs[2] = '{1'b1, 5'd0, 6'd9,  1'b0, 6'd0,  1'b0, 5'd0, 6'd0,  2};
    vecs[3] = '{1'b0, 5'd0, 6'd0,  1'b1, 6'd34, 1'b0, 5'd4, 6'd21, 2};
    vecs[4] = '{1'b1, 5'd9, 6'd44, 1'b0, 6'd0,  1'b0, 5'd9, 6'd44, 2};
    vecs[5] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 5'd9, 6'd44, 1};
    vecs[6] = '{1'b1, 5'd9, 6'd45, 1'b1, 6'd46, 1'b1, 5'd9, 6'd45, 3};
    vecs[7] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 5'd1, 6'd1,  2};
    vecs[8] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 5'd2, 6'd2,  1};
    vecs[9] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 5'd4, 6'd21, 0};

    // Reset state.
    step();
    step();
    RST = 1'b0;
    chk_en = 1'b1;
    RD_ARCH = 5'd5;
    #1;
    check("rst_count", {28'd0, COUNT}, 32'd0);
    check("rst_control", {30'd0, CONTROL}, 32'd0);
    check("rst_free", {26'd0, FREE}, 32'd0);
    check("rst_rd5", {26'd0, RD_PHYS}, 32'd5);
    check("rst_ready", {30'd0, RET_READY, SQ_READY}, 32'd3);

    // Single retire, then its old mapping is freed.
    RET_VALID = 1'b1; RET_ARCH = 5'd3; RET_PHYS = 6'd40;
    step();
    idle();
    RD_ARCH = 5'd3;
    #1;
    check("t2_control", {30'd0, CONTROL}, 32'd2);
    check("t2_free", {26'd0, FREE}, 32'd3);
    check("t2_count", {28'd0, COUNT}, 32'd1);
    check("t2_rd3", {26'd0, RD_PHYS}, 32'd40);
    step();
    check("t2_count0", {28'd0, COUNT}, 32'd0);

    // Retire and squash together: retire entry goes first.
    RET_VALID = 1'b1; RET_ARCH = 5'd7; RET_PHYS = 6'd41;
    SQ_VALID = 1'b1; SQ_PHYS = 6'd50;
    step();
    idle();
    #1;
    check("t3_free7", {26'd0, FREE}, 32'd7);
    check("t3_count2", {28'd0, COUNT}, 32'd2);
    step();
    check("t3_free50", {26'd0, FREE}, 32'd50);
    check("t3_count1", {28'd0, COUNT}, 32'd1);
    step();
    check("t3_count0", {28'd0, COUNT}, 32'd0);
    check("t3_idle", {30'd0, CONTROL}, 32'd0);

    // Retire to arch 0 pushes nothing.
    RET_VALID = 1'b1; RET_ARCH = 5'd0; RET_PHYS = 6'd60;
    step();
    idle();
    RD_ARCH = 5'd0;
    #1;
    check("t5_count", {28'd0, COUNT}, 32'd0);
    check("t5_rd0", {26'd0, RD_PHYS}, 32'd0);
    check("t5_control", {30'd0, CONTROL}, 32'd0);
    step();

    // Claim held while retiring arch 1..8: queue fills, ready drops at 7.
    do_reset();
    emitted.delete();
    CLAIM_REQ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bit fired;
      int guard;
      RET_VALID = 1'b1; RET_ARCH = 5'(i); RET_PHYS = 6'(10 + i);
      if (i == 8) begin
        #1;
        check("t4_count7", {28'd0, COUNT}, 32'd7);
        check("t4_ready_drop", {31'd0, RET_READY}, 32'd0);
        check("t4_claim_idle", {30'd0, CONTROL}, 32'd0);
        CLAIM_REQ = 1'b0;
      end
      fired = 1'b0;
      guard = 0;
      while (!fired && guard < 20) begin
        fired = RET_READY;
        step();
        guard++;
      end
      check("t4_fire", {31'd0, fired}, 32'd1);
    end
    drain("t4_drain");
    check("t4_emit_cnt", emitted.size(), 32'd8);
    for (int k = 0; k < emitted.size() && k < 8; k++) begin
      check($sformatf("t4_emit%0d", k), {26'd0, emitted[k]}, k + 1);
    end

    // Table of single-cycle vectors from the identity map.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      RET_VALID = vecs[k].ret_v; RET_ARCH = vecs[k].ret_arch; RET_PHYS = vecs[k].ret_phys;
      SQ_VALID = vecs[k].sq_v; SQ_PHYS = vecs[k].sq_phys;
      CLAIM_REQ = vecs[k].claim; RD_ARCH = vecs[k].rd_arch;
      step();
      check($sformatf("vec%0d_rd", k), {26'd0, RD_PHYS}, {26'd0, vecs[k].exp_rd});
      check($sformatf("vec%0d_count", k), {28'd0, COUNT}, vecs[k].exp_count);
    end
    idle();
    CLAIM_REQ = 1'b0;

    // Random traffic under the scoreboard.
    for (int n = 0; n < 200; n++) begin
      RET_VALID = 1'($urandom_range(0, 1));
      RET_ARCH  = 5'($urandom_range(0, 31));
      RET_PHYS  = 6'($urandom_range(0, 63));
      SQ_VALID  = 1'($urandom_range(0, 1));
      SQ_PHYS   = 6'($urandom_range(0, 63));
      CLAIM_REQ = ($urandom_range(0, 3) == 0);
      RD_ARCH   = 5'($urandom_range(0, 31));
      step();
    end
    drain("rand_drain");

    // Reset with queued entries: nothing queued is ever emitted.
    CLAIM_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SQ_VALID = 1'b1; SQ_PHYS = 6'(30 + i);
      step();
    end
    idle();
    #1;
    check("t6_count4", {28'd0, COUNT}, 32'd4);
    RST = 1'b1;
    step();
    RST = 1'b0;
    CLAIM_REQ = 1'b0;
    RD_ARCH = 5'd4;
    emitted.delete();
    #1;
    check("t6_count0", {28'd0, COUNT}, 32'd0);
    check("t6_control", {30'd0, CONTROL}, 32'd0);
    check("t6_free", {26'd0, FREE}, 32'd0);
    check("t6_rd4", {26'd0, RD_PHYS}, 32'd4);
    for (int i = 0; i < 3; i++) step();
    check("t6_no_emit", emitted.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
